// File: rtl/hynoc_egress_arbiter_if.sv
// Egress arbiter bundle: ingress request/write/data in, grant/afull back,
// plus the write side of the egress FIFO.
// master = arbiter side, slave = environment (ingress blocks + FIFO).
interface hynoc_egress_arbiter_if #(
  parameter int NB_REQ          = 4,
  parameter int FLIT_WIDTH      = 33,
  parameter int LOG2_FIFO_DEPTH = 5
);
  logic [NB_REQ-1:0]            from_ingress_request;
  logic [NB_REQ-1:0]            from_ingress_write;
  logic [NB_REQ*FLIT_WIDTH-1:0] from_ingress_data;
  logic [NB_REQ-1:0]            to_ingress_grant;
  logic [NB_REQ-1:0]            to_ingress_afull;
  logic [LOG2_FIFO_DEPTH:0]     fifo_wlevel;
  logic                         fifo_wen;
  logic [FLIT_WIDTH-1:0]        fifo_wdata;

  modport master (
    input  from_ingress_request,
    input  from_ingress_write,
    input  from_ingress_data,
    input  fifo_wlevel,
    output to_ingress_grant,
    output to_ingress_afull,
    output fifo_wen,
    output fifo_wdata
  );

  modport slave (
    output from_ingress_request,
    output from_ingress_write,
    output from_ingress_data,
    output fifo_wlevel,
    input  to_ingress_grant,
    input  to_ingress_afull,
    input  fifo_wen,
    input  fifo_wdata
  );
endinterface

// File: rtl/hynoc_egress_arbiter.sv
// hynoc per-output-port arbiter: grants whole packets to one ingress at a
// time in round-robin order, forwards the granted flits into the egress FIFO
// and returns almost-full back-pressure to the granted ingress only.
module hynoc_egress_arbiter #(
  parameter int NB_REQ          = 4,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int AFULL_MARGIN    = 5
) (
  input  logic                   router_clk,
  input  logic                   router_arst_n,
  hynoc_egress_arbiter_if.master bus,
  output logic [15:0]            pkt_count,
  output logic [7:0]             drop_count
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam logic [LOG2_FIFO_DEPTH:0] AFULL_LEVEL =
    (LOG2_FIFO_DEPTH+1)'((2 ** LOG2_FIFO_DEPTH) - AFULL_MARGIN);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   scan_sel;
  logic               scan_hit;
  logic [NB_REQ-1:0]  grant_q, grant_d;
  logic [NB_REQ-1:0]  afull_q;
  logic               wen_q;
  logic [FLIT_WIDTH-1:0] wdata_q;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic               grant_write;
  logic               pkt_done;
  logic               stray;
  logic [15:0]        pkt_q;
  logic [7:0]         drop_q;

  // Round-robin scan: first requester at index >= rr pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    scan_hit = 1'b0;
    scan_sel = rr_q;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!scan_hit && bus.from_ingress_request[idx]) begin
        scan_hit = 1'b1;
        scan_sel = IDX_W'(idx);
      end
    end
  end

  // Flit of the selected ingress and write/drop qualification.
  always_comb begin
    sel_flit    = bus.from_ingress_data[sel_q*FLIT_WIDTH +: FLIT_WIDTH];
    grant_write = (state_q == GRANT) && bus.from_ingress_write[sel_q];
    pkt_done    = grant_write && sel_flit[FLIT_WIDTH-1];
    // grant_q is zero outside GRANT, so this covers IDLE/RELEASE writes too
    stray       = |(bus.from_ingress_write & ~grant_q);
  end

  // FSM state, selected ingress and round-robin pointer.
  always_ff @(posedge router_clk or negedge router_arst_n) begin
    if (!router_arst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic: packet grant, completion/abort and release gap.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        if (scan_hit) begin
          state_d = GRANT;
          sel_d   = scan_sel;
        end
      end
      GRANT: begin
        // last flit or request withdrawn: both end the packet, pointer moves on
        if (pkt_done || !bus.from_ingress_request[sel_q]) begin
          state_d = RELEASE;
          rr_d    = (sel_q == IDX_W'(NB_REQ-1)) ? '0 : sel_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT) grant_d = NB_REQ'(1) << sel_d;
  end

  // Registered grant/afull, FIFO write path and statistics counters.
  always_ff @(posedge router_clk or negedge router_arst_n) begin
    if (!router_arst_n) begin
      grant_q <= '0;
      afull_q <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      grant_q <= grant_d;
      afull_q <= (bus.fifo_wlevel >= AFULL_LEVEL) ? grant_d : '0;
      wen_q   <= grant_write;
      if (grant_write) wdata_q <= sel_flit;
      if (pkt_done) pkt_q <= pkt_q + 16'd1;
      if (stray && (drop_q != '1)) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.to_ingress_grant = grant_q;
  assign bus.to_ingress_afull = afull_q;
  assign bus.fifo_wen         = wen_q;
  assign bus.fifo_wdata       = wdata_q;
  assign pkt_count            = pkt_q;
  assign drop_count           = drop_q;

endmodule

// File: tb/tb_hynoc_egress_arbiter.sv
// Self-checking bench for hynoc_egress_arbiter: directed scenarios plus a
// randomized run against a packet-level reference model.
module tb_hynoc_egress_arbiter;

  localparam int NB       = 4;
  localparam int PW       = 32;
  localparam int FW       = PW + 1;
  localparam int L2       = 5;
  localparam int MARGIN   = 5;
  localparam int AF_LEVEL = (1 << L2) - MARGIN;

  logic          router_clk = 1'b0;
  logic          router_arst_n = 1'b0;
  logic [15:0]   pkt_count;
  logic [7:0]    drop_count;

  logic [NB-1:0] req = '0;
  logic [NB-1:0] wr = '0;
  logic [FW-1:0] flit [NB];
  logic [L2:0]   lvl = '0;
  logic [NB*FW-1:0] data_bus;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (packet level)
  int            m_cur;
  int            m_gap;
  int            m_rr;
  int unsigned   m_pkt;
  int unsigned   m_drop;
  logic          m_wen;
  logic [FW-1:0] m_wdata;
  logic [NB-1:0] m_grant;
  logic [NB-1:0] m_afull;

  hynoc_egress_arbiter_if #(.NB_REQ(NB), .FLIT_WIDTH(FW), .LOG2_FIFO_DEPTH(L2)) bus ();

  hynoc_egress_arbiter #(
    .NB_REQ(NB), .PAYLOAD_WIDTH(PW), .FLIT_WIDTH(FW),
    .LOG2_FIFO_DEPTH(L2), .AFULL_MARGIN(MARGIN)
  ) dut (
    .router_clk(router_clk),
    .router_arst_n(router_arst_n),
    .bus(bus.master),
    .pkt_count(pkt_count),
    .drop_count(drop_count)
  );

  always #5 router_clk = ~router_clk;

  always_comb begin
    data_bus = '0;
    for (int i = 0; i < NB; i++) data_bus[i*FW +: FW] = flit[i];
  end

  assign bus.from_ingress_request = req;
  assign bus.from_ingress_write   = wr;
  assign bus.from_ingress_data    = data_bus;
  assign bus.fifo_wlevel          = lvl;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_cur = -1; m_gap = 0; m_rr = 0; m_pkt = 0; m_drop = 0;
    m_wen = 1'b0; m_wdata = '0; m_grant = '0; m_afull = '0;
  endtask

  // One clock: predict from the current inputs, advance, land at edge+1.
  task automatic cycle();
    int n_cur; int n_gap; logic n_wen; logic [FW-1:0] n_wdata;
    logic [NB-1:0] others; bit found;
    n_cur = m_cur; n_gap = m_gap; n_wen = 1'b0; n_wdata = m_wdata; others = wr;
    if (m_cur >= 0) begin
      others[m_cur] = 1'b0;
      if (wr[m_cur]) begin n_wen = 1'b1; n_wdata = flit[m_cur]; end
      if (wr[m_cur] && flit[m_cur][FW-1]) m_pkt = (m_pkt + 1) % 65536;
      if ((wr[m_cur] && flit[m_cur][FW-1]) || !req[m_cur]) begin
        m_rr = (m_cur + 1) % NB; n_cur = -1; n_gap = 1;
      end
    end else if (m_gap > 0) begin
      n_gap = m_gap - 1;
    end else begin
      found = 1'b0;
      for (int k = 0; k < NB; k++) begin
        if (!found && req[(m_rr + k) % NB]) begin found = 1'b1; n_cur = (m_rr + k) % NB; end
      end
    end
    if (others != '0 && m_drop < 255) m_drop++;
    @(posedge router_clk); #1;
    m_cur = n_cur; m_gap = n_gap; m_wen = n_wen; m_wdata = n_wdata;
    m_grant = (n_cur >= 0) ? NB'(1 << n_cur) : '0;
    m_afull = (n_cur >= 0 && int'(lvl) >= AF_LEVEL) ? m_grant : '0;
  endtask

  task automatic do_reset();
    router_arst_n = 1'b0;
    req = '0; wr = '0; lvl = '0;
    for (int i = 0; i < NB; i++) flit[i] = '0;
    model_reset();
    repeat (2) @(posedge router_clk);
    #1 router_arst_n = 1'b1;
  endtask

  task automatic test_reset();
    router_arst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req = NB'($urandom); wr = NB'($urandom); lvl = (L2+1)'($urandom_range(0, 32));
      for (int i = 0; i < NB; i++) flit[i] = {1'($urandom), 32'($urandom)};
      @(posedge router_clk); #1;
      vectors++;
      if (bus.to_ingress_grant !== '0 || bus.fifo_wen !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: grant=%b wen=%b, want 0", bus.to_ingress_grant, bus.fifo_wen);
      end
    end
    vectors++;
    if (bus.to_ingress_afull !== '0 || bus.fifo_wdata !== '0 || pkt_count !== 16'd0 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: afull=%b wdata=%h pkt=%0d drop=%0d, want all 0",
               bus.to_ingress_afull, bus.fifo_wdata, pkt_count, drop_count);
    end
    req = '0; wr = '0; lvl = '0;
    model_reset();
    router_arst_n = 1'b1;
    req = 4'b0100;
    #2;
    vectors++;
    if (bus.to_ingress_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_pre_grant: grant=%b want 0000", bus.to_ingress_grant);
    end
    cycle();
    vectors++;
    if (bus.to_ingress_grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_grant_latency: grant=%b want 0100", bus.to_ingress_grant);
    end
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] pk [4];
    pk[0] = 33'h0_00000011; pk[1] = 33'h0_00000012;
    pk[2] = 33'h0_00000013; pk[3] = 33'h1_CAFEDECA;
    do_reset();
    req = 4'b0100;
    cycle();
    for (int i = 0; i < 4; i++) begin
      wr = 4'b0100; flit[2] = pk[i];
      cycle();
      vectors++;
      if (bus.fifo_wen !== 1'b1 || bus.fifo_wdata !== pk[i]) begin
        miscompares++;
        $display("FAIL single_flit%0d: wen=%b data=%h want 1 %h", i, bus.fifo_wen, bus.fifo_wdata, pk[i]);
      end
      vectors++;
      if (bus.to_ingress_grant !== ((i < 3) ? 4'b0100 : 4'b0000)) begin
        miscompares++;
        $display("FAIL single_grant%0d: grant=%b", i, bus.to_ingress_grant);
      end
    end
    vectors++;
    if (pkt_count !== 16'd1 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL single_counts: pkt=%0d drop=%0d want 1 0", pkt_count, drop_count);
    end
    wr = '0; req = '0;
    cycle();
    vectors++;
    if (bus.fifo_wen !== 1'b0 || bus.to_ingress_grant !== '0) begin
      miscompares++;
      $display("FAIL single_after: wen=%b grant=%b want 0", bus.fifo_wen, bus.to_ingress_grant);
    end
  endtask

  task automatic test_round_robin();
    int waited; int e; logic [FW-1:0] f;
    do_reset();
    req = 4'b1111;
    for (int p = 0; p < 8; p++) begin
      e = p % NB;
      waited = 0;
      while (bus.to_ingress_grant === '0 && waited < 8) begin cycle(); waited++; end
      vectors++;
      if (bus.to_ingress_grant !== NB'(1 << e)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: grant=%b want %b (waited %0d)", p, bus.to_ingress_grant, NB'(1 << e), waited);
      end
      wr = NB'(1 << e);
      for (int j = 0; j < 2; j++) begin
        f = {(j == 1) ? 1'b1 : 1'b0, 32'($urandom)};
        flit[e] = f;
        cycle();
        vectors++;
        if (bus.fifo_wen !== 1'b1 || bus.fifo_wdata !== f) begin
          miscompares++;
          $display("FAIL rr_data%0d_%0d: wen=%b data=%h want 1 %h", p, j, bus.fifo_wen, bus.fifo_wdata, f);
        end
      end
      wr = '0;
      vectors++;
      if (bus.to_ingress_grant !== '0) begin
        miscompares++;
        $display("FAIL rr_gap%0d: grant=%b want 0000", p, bus.to_ingress_grant);
      end
    end
    vectors++;
    if (pkt_count !== 16'd8 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rr_counts: pkt=%0d drop=%0d want 8 0", pkt_count, drop_count);
    end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] want;
    do_reset();
    lvl = 6'd30;
    cycle();
    vectors++;
    if (bus.to_ingress_afull !== '0) begin
      miscompares++;
      $display("FAIL bp_idle: afull=%b want 0000", bus.to_ingress_afull);
    end
    lvl = '0; req = 4'b0010;
    cycle();
    lvl = 6'd27;
    cycle();
    vectors++;
    if (bus.to_ingress_afull !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_assert: afull=%b want 0010", bus.to_ingress_afull);
    end
    lvl = 6'd26;
    cycle();
    vectors++;
    if (bus.to_ingress_afull !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_deassert: afull=%b want 0000", bus.to_ingress_afull);
    end
    for (int c = 0; c < 24; c++) begin
      lvl = (L2+1)'($urandom_range(0, 32));
      cycle();
      want = (int'(lvl) >= AF_LEVEL) ? 4'b0010 : 4'b0000;
      vectors++;
      if (bus.to_ingress_afull !== want) begin
        miscompares++;
        $display("FAIL bp_level%0d: lvl=%0d afull=%b want %b", c, lvl, bus.to_ingress_afull, want);
      end
    end
    lvl = 6'd32; req = '0;
    cycle();
    vectors++;
    if (bus.to_ingress_afull !== '0 || bus.to_ingress_grant !== '0) begin
      miscompares++;
      $display("FAIL bp_release: afull=%b grant=%b want 0", bus.to_ingress_afull, bus.to_ingress_grant);
    end
  endtask

  task automatic test_stray_writes();
    int want;
    do_reset();
    req = 4'b0001;
    cycle();
    wr = 4'b1110;
    for (int i = 0; i < NB; i++) flit[i] = {1'b1, 32'($urandom)};
    cycle();
    vectors++;
    if (bus.fifo_wen !== 1'b0 || drop_count !== 8'd1) begin
      miscompares++;
      $display("FAIL stray_multi: wen=%b drop=%0d want 0 1", bus.fifo_wen, drop_count);
    end
    wr = 4'b1000;
    for (int n = 0; n < 299; n++) begin
      flit[3] = {1'($urandom), 32'($urandom)};
      cycle();
      want = (n + 2 > 255) ? 255 : n + 2;
      vectors++;
      if (bus.fifo_wen !== 1'b0 || drop_count !== 8'(want) || bus.to_ingress_grant !== 4'b0001) begin
        miscompares++;
        $display("FAIL stray_%0d: wen=%b drop=%0d grant=%b want 0 %0d 0001",
                 n, bus.fifo_wen, drop_count, bus.to_ingress_grant, want);
      end
    end
    wr = '0;
  endtask

  task automatic test_abort_and_reset();
    int waited;
    do_reset();
    req = 4'b0001;
    cycle();
    wr = 4'b0001; flit[0] = {1'b0, 32'h0000_0A0A};
    cycle();
    vectors++;
    if (bus.fifo_wen !== 1'b1 || bus.fifo_wdata !== {1'b0, 32'h0000_0A0A}) begin
      miscompares++;
      $display("FAIL abort_flit: wen=%b data=%h", bus.fifo_wen, bus.fifo_wdata);
    end
    wr = '0; req = '0;
    cycle();
    vectors++;
    if (bus.to_ingress_grant !== '0 || pkt_count !== 16'd0) begin
      miscompares++;
      $display("FAIL abort_release: grant=%b pkt=%0d want 0000 0", bus.to_ingress_grant, pkt_count);
    end
    req = 4'b1111;
    waited = 0;
    while (bus.to_ingress_grant === '0 && waited < 8) begin cycle(); waited++; end
    vectors++;
    if (bus.to_ingress_grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_rr: grant=%b want 0010 (waited %0d)", bus.to_ingress_grant, waited);
    end
    wr = 4'b0010; flit[1] = {1'b0, 32'h1234_5678};
    cycle();
    #2 router_arst_n = 1'b0;
    #1;
    vectors++;
    if (bus.to_ingress_grant !== '0 || bus.fifo_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: grant=%b wen=%b want 0000 0", bus.to_ingress_grant, bus.fifo_wen);
    end
    wr = '0; req = '0;
    model_reset();
    @(posedge router_clk);
    #1 router_arst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (i == m_cur) req[i] = ($urandom_range(0, 99) < 97);
        else            req[i] = ($urandom_range(0, 3) != 0);
        if (i == m_cur) wr[i] = ($urandom_range(0, 9) < 7);
        else            wr[i] = ($urandom_range(0, 99) < 2);
        flit[i] = {($urandom_range(0, 3) == 0), 32'($urandom)};
      end
      lvl = (L2+1)'($urandom_range(0, 32));
      cycle();
      vectors++;
      if (bus.to_ingress_grant !== m_grant || bus.to_ingress_afull !== m_afull) begin
        miscompares++;
        $display("FAIL rand_grant%0d: grant=%b afull=%b want %b %b",
                 c, bus.to_ingress_grant, bus.to_ingress_afull, m_grant, m_afull);
      end
      vectors++;
      if (bus.fifo_wen !== m_wen || bus.fifo_wdata !== m_wdata) begin
        miscompares++;
        $display("FAIL rand_fifo%0d: wen=%b data=%h want %b %h", c, bus.fifo_wen, bus.fifo_wdata, m_wen, m_wdata);
      end
      vectors++;
      if (pkt_count !== m_pkt[15:0] || drop_count !== m_drop[7:0]) begin
        miscompares++;
        $display("FAIL rand_count%0d: pkt=%0d drop=%0d want %0d %0d", c, pkt_count, drop_count, m_pkt, m_drop);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) flit[i] = '0;
    model_reset();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_stray_writes();
    test_abort_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hynoc_egress_arbiter.md
Name: hynoc_egress_arbiter

Overview:
- Per-output-port arbiter/scheduler of the hynoc router.
- Shares one egress FIFO write port among NB_REQ ingress blocks.
- Grants whole packets (circuit-switch) in round-robin order and forwards the granted ingress flits to the egress FIFO.
- Generates the per-ingress grant and almost-full back-pressure that each hynoc_ingress consumes.

Parameters:
- NB_REQ, 4, number of ingress requesters (NB_PORTS-1).
- PAYLOAD_WIDTH, 32, flit payload width.
- FLIT_WIDTH, PAYLOAD_WIDTH+1, flit width; MSB set marks the last flit of a packet.
- LOG2_FIFO_DEPTH, 5, log2 of the downstream egress FIFO depth.
- AFULL_MARGIN, 5, free-slot threshold for almost-full.

Ports:
- router_clk  in  1  router clock
- router_arst_n  in  1  asynchronous active-low reset
- from_ingress_request  in  NB_REQ  bit i: ingress i requests this egress
- from_ingress_write  in  NB_REQ  bit i: ingress i presents a valid flit
- from_ingress_data  in  NB_REQ*FLIT_WIDTH  flit of ingress i at [i*FLIT_WIDTH +: FLIT_WIDTH]
- to_ingress_grant  out  NB_REQ  one-hot grant
- to_ingress_afull  out  NB_REQ  almost-full, asserted only toward the granted ingress
- fifo_wlevel  in  LOG2_FIFO_DEPTH+1  egress FIFO fill level
- fifo_wen  out  1  egress FIFO write enable
- fifo_wdata  out  FLIT_WIDTH  egress FIFO write data
- pkt_count  out  16  completed packets, wraps at 0xFFFF -> 0
- drop_count  out  8  ignored writes, saturates at 0xFF

Behaviour:
- Reset (async assert, sync release) sets all outputs to 0, state=IDLE, rr_ptr=0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: if from_ingress_request!=0, sel = first requester at index >= rr_ptr, scanning modulo NB_REQ. Next cycle: state=GRANT and to_ingress_grant=1<<sel. Request-to-grant latency is 1 cycle. If no request, stay in IDLE.
- GRANT, granted write:
  - A write from the granted ingress is registered: fifo_wen=1 and fifo_wdata=flit on the next cycle (1-cycle latency).
  - If the flit MSB=1, go to RELEASE: grant drops the next cycle, pkt_count increments, rr_ptr=(sel+1) mod NB_REQ.
- GRANT, request dropped with no last flit (abort): go to RELEASE with the same pointer update; pkt_count is not incremented.
- RELEASE: one cycle with all grants low, then IDLE. This guarantees at least one grant-free cycle between packets.
- A write from any non-granted ingress, or any write while in IDLE/RELEASE, is ignored and increments drop_count (saturating).
  - Several such writes in one cycle add 1 only.
- to_ingress_afull[sel] = registered (fifo_wlevel >= 2**LOG2_FIFO_DEPTH - AFULL_MARGIN), qualified by grant; every other bit is 0.
  - The arbiter never withholds a write because of afull: the ingress stops writing and the margin absorbs pipeline flits.
- Simultaneous last flit and new requests: the new requests are arbitrated in the IDLE after RELEASE, using the updated rr_ptr.
- A flit with MSB=1 as the first flit (single-flit packet) completes the packet normally.
- Reset asserted mid-packet clears grant, fifo_wen and state immediately; a partial packet may remain downstream.

Test Plan:
- Reset: hold router_arst_n=0 with random inputs -> all outputs 0. Release, then request=4'b0100 -> grant=4'b0100 exactly 1 cycle later.
- Single packet: ingress 2 writes 0x0_00000011..0x0_00000013 then 0x1_CAFEDECA -> fifo_wen for 4 consecutive cycles, each 1 cycle after its write, same data. Grant low 1 cycle after the last flit; pkt_count=1.
- Round robin: request=4'b1111 for 8 packets of 2 flits each -> grant order 0,1,2,3,0,1,2,3 with one grant-free cycle between packets; pkt_count=8.
- Back-pressure: fifo_wlevel=27 while ingress 1 is granted -> to_ingress_afull=4'b0010 next cycle. fifo_wlevel=26 -> afull deasserts; other afull bits stay 0 throughout.
- Stray writes: ingress 3 writes while ingress 0 is granted, 300 times -> no fifo_wen from ingress 3, drop_count saturates at 0xFF.
- Abort and reset: ingress 0 drops its request mid-packet -> grant released, pkt_count unchanged, rr_ptr=1. Assert reset during a packet -> grant and fifo_wen go to 0 asynchronously.
